// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and access-type encoding for the load/store unit.
package lsu_pkg;
    localparam logic [31:0] UART_BASE_DEF = 32'h8000_0000;
    localparam logic [1:0]  REG_TXDATA    = 2'd0;
    localparam logic [1:0]  REG_RXDATA    = 2'd1;
    localparam logic [1:0]  REG_STATUS    = 2'd2;
    localparam logic [1:0]  REG_CTRL      = 2'd3;
    localparam int          ST_TX_FULL    = 0;
    localparam int          ST_TX_EMPTY   = 1;
    localparam int          ST_RX_FULL    = 2;
    localparam int          ST_RX_EMPTY   = 3;
    localparam int          ST_RX_OVF     = 4;
    // {is_store, funct3}: loads and stores share funct3 codes, so the store bit keeps members unique
    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } ls_op_e;
endpackage

// File: rtl/lsu_mmio_if.sv
// lsu_mmio_if: MEM-stage request/response bus between the pipeline and the load/store unit.
interface lsu_mmio_if;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rdata;
    logic        stall;
    modport master (output rd_en, wr_en, funct3, addr, wr_data, input rdata, stall);
    modport slave  (input rd_en, wr_en, funct3, addr, wr_data, output rdata, stall);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO with an extra pointer bit to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wp_q, wp_d, rp_q, rp_d;
    always_comb begin
        wp_d = wp_q + (AW+1)'(push);
        rp_d = rp_q + (AW+1)'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end
    always_ff @(posedge clk)
        if (push) mem_q[wp_q[AW-1:0]] <= din;
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign empty = wp_q == rp_q;
    assign dout  = mem_q[rp_q[AW-1:0]];
endmodule

// File: rtl/lsu_mmio.sv
// lsu_mmio: MEM-stage load/store unit steering accesses to data memory (with lane handling)
// or to per-channel memory-mapped UART TX/RX FIFOs.
module lsu_mmio
    import lsu_pkg::*;
#(
    parameter int          N_UART     = 2,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] UART_BASE  = UART_BASE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    lsu_mmio_if.slave           bus,
    output logic                mem_rd_en,
    output logic                mem_wr_en,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wr_data,
    output logic [3:0]          mem_byte_en,
    input  logic [31:0]         mem_rdata,
    input  logic [N_UART-1:0]   uart_rx_valid,
    input  logic [8*N_UART-1:0] uart_rx_data,
    input  logic [N_UART-1:0]   uart_tx_ready,
    output logic [N_UART-1:0]   uart_tx_en,
    output logic [8*N_UART-1:0] uart_tx_data
);
    logic                     is_uart;
    logic [5:0]               uart_sel;
    logic [3:0]               ch;
    logic [1:0]               rsel;
    ls_op_e                   op;
    logic [7:0]               ld_byte;
    logic [15:0]              ld_half;
    logic [3:0]               be;
    logic [31:0]              mem_load, uart_load;
    logic [N_UART-1:0]        stall_v;
    logic [N_UART-1:0][31:0]  rd_word;

    assign is_uart  = bus.addr[31];
    assign uart_sel = bus.addr[7:2] - UART_BASE[7:2];
    assign ch       = uart_sel[5:2];
    assign rsel     = uart_sel[1:0];
    assign op       = ls_op_e'({bus.wr_en, bus.funct3});
    assign ld_byte  = 8'(mem_rdata >> {bus.addr[1:0], 3'b000});
    assign ld_half  = bus.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign mem_addr = {bus.addr[31:2], 2'b00};

    always_comb begin
        mem_load    = '0;
        be          = '0;
        mem_wr_data = bus.wr_data;
        case (op)
            LB:  mem_load = {{24{ld_byte[7]}}, ld_byte};
            LBU: mem_load = {24'b0, ld_byte};
            LH:  mem_load = {{16{ld_half[15]}}, ld_half};
            LHU: mem_load = {16'b0, ld_half};
            LW:  mem_load = mem_rdata;
            SB: begin
                be          = 4'b0001 << bus.addr[1:0];
                mem_wr_data = {4{bus.wr_data[7:0]}};
            end
            SH: begin
                be          = bus.addr[1] ? 4'b1100 : 4'b0011;
                mem_wr_data = {2{bus.wr_data[15:0]}};
            end
            SW:  be = 4'hF;
            default: ;
        endcase
        uart_load = '0;
        for (int k = 0; k < N_UART; k++) uart_load |= rd_word[k];
    end

    assign mem_rd_en   = bus.rd_en && !is_uart;
    assign mem_wr_en   = bus.wr_en && !is_uart && |be;
    assign mem_byte_en = is_uart ? 4'b0 : be;
    assign bus.rdata   = !bus.rd_en ? '0 : is_uart ? uart_load : mem_load;
    assign bus.stall   = |stall_v;

    for (genvar i = 0; i < N_UART; i++) begin : g_ch
        logic        hit, tx_full, tx_empty, rx_full, rx_empty;
        logic        tx_push, rx_push, rx_pop, ovf_set, ovf_clr, ovf_q, ovf_d;
        logic [7:0]  rx_head;
        logic [31:0] status;
        assign hit       = is_uart && ch == 4'(i);
        assign tx_push   = bus.wr_en && hit && rsel == REG_TXDATA && !tx_full;
        assign rx_pop    = bus.rd_en && hit && rsel == REG_RXDATA && !rx_empty;
        // a same-cycle pop frees the slot, so a full FIFO still accepts the byte
        assign rx_push   = uart_rx_valid[i] && (!rx_full || rx_pop);
        assign ovf_set   = uart_rx_valid[i] && rx_full && !rx_pop;
        assign ovf_clr   = bus.wr_en && hit && rsel == REG_CTRL && bus.wr_data[0];
        assign stall_v[i]    = bus.wr_en && hit && rsel == REG_TXDATA && tx_full;
        assign uart_tx_en[i] = !tx_empty && uart_tx_ready[i];
        always_comb begin
            ovf_d               = (ovf_q && !ovf_clr) || ovf_set;
            status              = '0;
            status[ST_TX_FULL]  = tx_full;
            status[ST_TX_EMPTY] = tx_empty;
            status[ST_RX_FULL]  = rx_full;
            status[ST_RX_EMPTY] = rx_empty;
            status[ST_RX_OVF]   = ovf_q;
        end
        always_ff @(posedge clk) ovf_q <= rst ? 1'b0 : ovf_d;
        assign rd_word[i] = !hit ? '0 :
                            rsel == REG_RXDATA ? {24'b0, rx_empty ? 8'h00 : rx_head} :
                            rsel == REG_STATUS ? status : '0;
        sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
            .clk(clk), .rst(rst), .push(tx_push), .pop(uart_tx_en[i]),
            .din(bus.wr_data[7:0]), .dout(uart_tx_data[8*i +: 8]),
            .full(tx_full), .empty(tx_empty)
        );
        sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
            .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
            .din(uart_rx_data[8*i +: 8]), .dout(rx_head),
            .full(rx_full), .empty(rx_empty)
        );
    end
endmodule

// File: tb/tb_lsu_mmio.sv
// tb_lsu_mmio: directed checks of memory lane handling, UART FIFOs, stall, overflow and reset.
module tb_lsu_mmio;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_addr, mem_wr_data, mem_rdata;
    logic [3:0]  mem_byte_en;
    logic [1:0]  uart_rx_valid, uart_tx_ready, uart_tx_en;
    logic [15:0] uart_rx_data, uart_tx_data;
    int          n_cmp = 0;
    int          n_bad = 0;

    lsu_mmio_if bus();

    lsu_mmio #(.N_UART(2), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
        .uart_tx_ready(uart_tx_ready), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        bus.rd_en   = rd;
        bus.wr_en   = wr;
        bus.funct3  = f3;
        bus.addr    = a;
        bus.wr_data = wd;
        #1;
    endtask

    task automatic nop();
        acc(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] ua(input int c, input int r);
        return 32'h8000_0000 + 32'(c * 16 + r * 4);
    endfunction

    task automatic st(input int c, input logic [31:0] exp, input string tag);
        acc(1'b1, 1'b0, 3'd2, ua(c, 2), 32'h0);
        chk(tag, bus.rdata, exp);
    endtask

    initial begin
        uart_rx_valid = '0;
        uart_rx_data  = '0;
        uart_tx_ready = '0;
        mem_rdata     = 32'h8001_7FFE;
        nop();
        tick();
        tick();
        rst = 1'b0;
        // reset state
        st(0, 32'h0A, "rst_status0");
        st(1, 32'h0A, "rst_status1");
        nop();
        chk("rst_tx_en", 32'(uart_tx_en), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);

        // memory loads from word 0x8001_7FFE
        acc(1, 0, 3'b000, 32'h101, 0);
        chk("lb_101", bus.rdata, 32'h0000_007F);
        chk("lb_mem_rd_en", 32'(mem_rd_en), 32'h1);
        chk("lb_mem_addr", mem_addr, 32'h100);
        acc(1, 0, 3'b000, 32'h103, 0);
        chk("lb_103", bus.rdata, 32'hFFFF_FF80);
        acc(1, 0, 3'b100, 32'h103, 0);
        chk("lbu_103", bus.rdata, 32'h0000_0080);
        acc(1, 0, 3'b001, 32'h102, 0);
        chk("lh_102", bus.rdata, 32'hFFFF_8001);
        acc(1, 0, 3'b101, 32'h100, 0);
        chk("lhu_100", bus.rdata, 32'h0000_7FFE);
        acc(1, 0, 3'b010, 32'h100, 0);
        chk("lw_100", bus.rdata, 32'h8001_7FFE);
        acc(1, 0, 3'b011, 32'h100, 0);
        chk("ld_bad_f3", bus.rdata, 32'h0);

        // memory stores
        acc(0, 1, 3'b000, 32'h102, 32'h1234_56AA);
        chk("sb_be", 32'(mem_byte_en), 32'h4);
        chk("sb_data", mem_wr_data, 32'hAAAA_AAAA);
        chk("sb_wr_en", 32'(mem_wr_en), 32'h1);
        acc(0, 1, 3'b001, 32'h103, 32'hDEAD_BEEF);
        chk("sh_be", 32'(mem_byte_en), 32'hC);
        chk("sh_data", mem_wr_data, 32'hBEEF_BEEF);
        acc(0, 1, 3'b010, 32'h101, 32'hDEAD_BEEF);
        chk("sw_be", 32'(mem_byte_en), 32'hF);
        chk("sw_data", mem_wr_data, 32'hDEAD_BEEF);
        acc(0, 1, 3'b011, 32'h100, 32'hDEAD_BEEF);
        chk("st_bad_wr_en", 32'(mem_wr_en), 32'h0);
        chk("st_bad_be", 32'(mem_byte_en), 32'h0);

        // UART-region isolation from data memory
        acc(0, 1, 3'b010, ua(0, 3), 32'h0);
        chk("iso_wr_en", 32'(mem_wr_en), 32'h0);
        chk("iso_be", 32'(mem_byte_en), 32'h0);
        acc(1, 0, 3'b010, ua(0, 2), 32'h0);
        chk("iso_rd_en", 32'(mem_rd_en), 32'h0);
        nop();

        // channel 1 TX fill with ready low
        for (int k = 0; k < 8; k++) begin
            acc(0, 1, 3'b010, ua(1, 0), 32'(8'h10 + k));
            chk("tx_fill_stall", 32'(bus.stall), 32'h0);
            tick();
        end
        nop();
        chk("tx_head", 32'(uart_tx_data[15:8]), 32'h10);
        chk("tx_en_not_ready", 32'(uart_tx_en), 32'h0);
        st(1, 32'h09, "tx_full_status");
        acc(0, 1, 3'b010, ua(1, 0), 32'h18);
        chk("tx_stall_full", 32'(bus.stall), 32'h1);
        uart_tx_ready = 2'b10;
        #1;
        chk("tx_drain_en", 32'(uart_tx_en), 32'h2);
        chk("tx_stall_ignores_drain", 32'(bus.stall), 32'h1);
        tick();
        uart_tx_ready = 2'b00;
        #1;
        chk("tx_stall_released", 32'(bus.stall), 32'h0);
        tick();
        nop();
        st(1, 32'h09, "tx_refilled_status");
        chk("tx_head_after_drain", 32'(uart_tx_data[15:8]), 32'h11);

        // channel 0 RX overflow
        nop();
        for (int k = 1; k <= 9; k++) begin
            uart_rx_valid = 2'b01;
            uart_rx_data  = 16'(k);
            tick();
        end
        uart_rx_valid = '0;
        st(0, 32'h16, "rx_ovf_status");
        for (int k = 1; k <= 8; k++) begin
            acc(1, 0, 3'b010, ua(0, 1), 32'h0);
            chk("rx_read", bus.rdata, 32'(k));
            tick();
        end
        st(0, 32'h1A, "rx_drained_status");
        acc(1, 0, 3'b010, ua(0, 1), 32'h0);
        chk("rx_read_empty", bus.rdata, 32'h0);
        tick();
        acc(0, 1, 3'b010, ua(0, 3), 32'h1);
        tick();
        st(0, 32'h0A, "ctrl_clear_status");

        // full RX with simultaneous pop and push
        nop();
        for (int k = 0; k < 8; k++) begin
            uart_rx_valid = 2'b01;
            uart_rx_data  = 16'(8'h21 + k);
            tick();
        end
        uart_rx_valid = '0;
        st(0, 32'h06, "rx_full_status");
        acc(1, 0, 3'b010, ua(0, 1), 32'h0);
        uart_rx_valid = 2'b01;
        uart_rx_data  = 16'h0029;
        #1;
        chk("rx_pushpop_read", bus.rdata, 32'h21);
        tick();
        uart_rx_valid = '0;
        st(0, 32'h06, "rx_pushpop_status");
        for (int k = 0; k < 8; k++) begin
            acc(1, 0, 3'b010, ua(0, 1), 32'h0);
            chk("rx_pushpop_drain", bus.rdata, 32'(8'h22 + k));
            tick();
        end
        st(0, 32'h0A, "rx_pushpop_empty");

        // unimplemented UART addresses
        acc(1, 0, 3'b010, 32'h8000_0020, 32'h0);
        chk("bad_ch_rdata", bus.rdata, 32'h0);
        chk("bad_ch_mem_rd_en", 32'(mem_rd_en), 32'h0);
        acc(0, 1, 3'b010, 32'h8000_0020, 32'h55);
        chk("bad_ch_stall", 32'(bus.stall), 32'h0);
        chk("bad_ch_mem_wr_en", 32'(mem_wr_en), 32'h0);
        tick();
        acc(1, 0, 3'b010, ua(0, 0), 32'h0);
        chk("rd_txdata_zero", bus.rdata, 32'h0);
        acc(1, 0, 3'b010, ua(0, 3), 32'h0);
        chk("rd_ctrl_zero", bus.rdata, 32'h0);
        acc(0, 1, 3'b010, ua(0, 1), 32'h77);
        tick();
        st(0, 32'h0A, "bad_wr_status0");
        st(1, 32'h09, "bad_wr_status1");

        // reset with FIFOs partially full
        nop();
        for (int k = 0; k < 2; k++) begin
            uart_rx_valid = 2'b01;
            uart_rx_data  = 16'(8'h40 + k);
            tick();
        end
        uart_rx_valid = '0;
        st(0, 32'h02, "pre_rst_status0");
        uart_tx_ready = 2'b11;
        #1;
        chk("pre_rst_tx_en", 32'(uart_tx_en), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_tx_en", 32'(uart_tx_en), 32'h0);
        st(0, 32'h0A, "post_rst_status0");
        st(1, 32'h0A, "post_rst_status1");
        nop();
        chk("post_rst_stall", 32'(bus.stall), 32'h0);
        chk("post_rst_rdata", bus.rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
